// File: rtl/wsp_ctrl_if.sv
// Wrapper serial port bundle: WSP control/data signals plus the boundary-register
// control and status lines. The controller is the slave side, the driving
// test access logic (or bench) is the master side.
interface wsp_ctrl_if;
    logic       wsi;
    logic       selectwir;
    logic       shiftwr;
    logic       capturewr;
    logic       updatewr;
    logic       transferdr;
    logic       wbr_so;
    logic       wso;
    logic       wbr_shift;
    logic       wbr_capture;
    logic       wbr_update;
    logic       wbr_transfer;
    logic       wbr_mode;
    logic       wbr_safe;
    logic       wbr_io_face;
    logic [2:0] instr;

    modport master (
        output wsi, selectwir, shiftwr, capturewr, updatewr, transferdr, wbr_so,
        input  wso, wbr_shift, wbr_capture, wbr_update, wbr_transfer,
               wbr_mode, wbr_safe, wbr_io_face, instr
    );

    modport slave (
        input  wsi, selectwir, shiftwr, capturewr, updatewr, transferdr, wbr_so,
        output wso, wbr_shift, wbr_capture, wbr_update, wbr_transfer,
               wbr_mode, wbr_safe, wbr_io_face, instr
    );
endinterface

// File: rtl/wsp_ctrl.sv
// Wrapper serial port controller: 3-bit wrapper instruction register (shift +
// update stages), 1-bit bypass register, and decode of the boundary-register
// controls from the active instruction. Unused codes 101-111 decode as bypass.
module wsp_ctrl (
    input  logic       clk,
    input  logic       arst,
    wsp_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        WS_BYPASS  = 3'b000,
        WS_EXTEST  = 3'b001,
        WS_INTEST  = 3'b010,
        WS_SAFE    = 3'b011,
        WS_PRELOAD = 3'b100
    } wir_instr_e;

    logic [2:0] wir_sr;
    logic [2:0] wir_ur;
    logic       wby;
    logic       wbr_sel;
    logic       dr_active;
    logic       mode_dec;
    logic       safe_dec;
    logic       io_face_dec;

    // WIR shift stage: capture reloads the active instruction and wins over shift.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wir_sr <= WS_BYPASS;
        end else if (bus.selectwir) begin
            if (bus.capturewr) begin
                wir_sr <= wir_ur;
            end else if (bus.shiftwr) begin
                wir_sr <= {bus.wsi, wir_sr[2:1]};
            end
        end
    end

    // WIR update stage: takes the pre-edge shift stage, even if it shifts or captures this cycle.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wir_ur <= WS_BYPASS;
        end else if (bus.selectwir && bus.updatewr) begin
            wir_ur <= wir_sr;
        end
    end

    // Bypass register: only moves on the data path while no boundary register is selected.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wby <= 1'b0;
        end else if (!bus.selectwir && !wbr_sel) begin
            if (bus.capturewr) begin
                wby <= 1'b0;
            end else if (bus.shiftwr) begin
                wby <= bus.wsi;
            end
        end
    end

    // Instruction decode: boundary-register selection and static cell controls.
    always_comb begin
        wbr_sel     = 1'b0;
        mode_dec    = 1'b0;
        safe_dec    = 1'b0;
        io_face_dec = 1'b0;
        case (wir_ur)
            WS_EXTEST: begin
                wbr_sel     = 1'b1;
                mode_dec    = 1'b1;
                io_face_dec = 1'b1;
            end
            WS_INTEST: begin
                wbr_sel  = 1'b1;
                mode_dec = 1'b1;
            end
            WS_SAFE: begin
                wbr_sel  = 1'b1;
                mode_dec = 1'b1;
                safe_dec = 1'b1;
            end
            WS_PRELOAD: begin
                wbr_sel     = 1'b1;
                io_face_dec = 1'b1;
            end
            default: begin
                wbr_sel = 1'b0;
            end
        endcase
    end

    assign dr_active = ~bus.selectwir & wbr_sel;

    assign bus.wbr_shift    = dr_active & bus.shiftwr & ~bus.capturewr;
    assign bus.wbr_capture  = dr_active & bus.capturewr;
    assign bus.wbr_update   = dr_active & bus.updatewr;
    assign bus.wbr_transfer = dr_active & bus.transferdr & ~bus.shiftwr & ~bus.capturewr;
    assign bus.wbr_mode     = mode_dec;
    assign bus.wbr_safe     = safe_dec;
    assign bus.wbr_io_face  = io_face_dec;
    assign bus.instr        = wir_ur;

    assign bus.wso = bus.selectwir ? wir_sr[0] : (wbr_sel ? bus.wbr_so : wby);

endmodule

// File: tb/tb_wsp_ctrl.sv
// Self-checking bench for wsp_ctrl. Expected output vectors are pushed to a
// scoreboard queue as each stimulus is driven and popped when the DUT is sampled
// on the falling edge. Vector layout:
// {instr[2:0], wbr_shift, wbr_capture, wbr_update, wbr_transfer,
//  wbr_mode, wbr_safe, wbr_io_face, wso}
// Stimulus layout: {selectwir, shiftwr, capturewr, updatewr, transferdr, wsi, wbr_so}
module tb_wsp_ctrl;

    typedef struct {
        string      tag;
        logic [10:0] value;
    } exp_t;

    logic clk;
    logic arst;
    int   checks;
    int   errors;
    exp_t sb[$];

    wsp_ctrl_if bus ();

    wsp_ctrl dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [10:0] observed();
        return {bus.instr, bus.wbr_shift, bus.wbr_capture, bus.wbr_update,
                bus.wbr_transfer, bus.wbr_mode, bus.wbr_safe, bus.wbr_io_face, bus.wso};
    endfunction

    task automatic apply(input logic [6:0] s);
        bus.selectwir  = s[6];
        bus.shiftwr    = s[5];
        bus.capturewr  = s[4];
        bus.updatewr   = s[3];
        bus.transferdr = s[2];
        bus.wsi        = s[1];
        bus.wbr_so     = s[0];
    endtask

    task automatic test_reset();
        exp_t e;
        logic [10:0] obs;
        arst = 1'b1;
        apply(7'b0000001);
        sb.push_back('{"reset_bypass_path", 11'b000_0000_000_0});
        #3;
        e = sb.pop_front();
        obs = observed();
        checks++;
        if (obs !== e.value) begin
            errors++;
            $display("[TB] FAIL %s got %b want %b", e.tag, obs, e.value);
        end
        apply(7'b1000001);
        sb.push_back('{"reset_wir_path", 11'b000_0000_000_0});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        obs = observed();
        checks++;
        if (obs !== e.value) begin
            errors++;
            $display("[TB] FAIL %s got %b want %b", e.tag, obs, e.value);
        end
        apply(7'b0000000);
        @(negedge clk);
        arst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_bypass();
        logic [6:0] stim [4] = '{7'b0100011, 7'b0100001, 7'b0100011, 7'b0100011};
        exp_t e;
        logic [10:0] obs;
        sb.push_back('{"bypass[0]", 11'b000_0000_000_0});
        for (int i = 0; i < 4; i++) begin
            apply(stim[i]);
            sb.push_back('{$sformatf("bypass[%0d]", i + 1), {10'b0, stim[i][1]}});
            @(negedge clk);
            e = sb.pop_front();
            obs = observed();
            checks++;
            if (obs !== e.value) begin
                errors++;
                $display("[TB] FAIL %s got %b want %b", e.tag, obs, e.value);
            end
            @(posedge clk);
            #1;
        end
        apply(7'b0000001);
        @(negedge clk);
        e = sb.pop_front();
        obs = observed();
        checks++;
        if (obs !== e.value) begin
            errors++;
            $display("[TB] FAIL %s got %b want %b", e.tag, obs, e.value);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_extest_load();
        logic [6:0]  stim [5] = '{7'b1100010, 7'b1100000, 7'b1100000, 7'b1001000, 7'b0000001};
        logic [10:0] expv [5] = '{11'b000_0000_000_0, 11'b000_0000_000_0, 11'b000_0000_000_0,
                                  11'b000_0000_000_1, 11'b001_0000_101_1};
        exp_t e;
        logic [10:0] obs;
        for (int i = 0; i < 5; i++) begin
            apply(stim[i]);
            sb.push_back('{$sformatf("extest_load[%0d]", i), expv[i]});
            @(negedge clk);
            e = sb.pop_front();
            obs = observed();
            checks++;
            if (obs !== e.value) begin
                errors++;
                $display("[TB] FAIL %s got %b want %b", e.tag, obs, e.value);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_extest_data();
        logic [6:0]  stim [4] = '{7'b0010000, 7'b0100001, 7'b0000100, 7'b0101101};
        logic [10:0] expv [4] = '{11'b001_0100_101_0, 11'b001_1000_101_1,
                                  11'b001_0001_101_0, 11'b001_1010_101_1};
        exp_t e;
        logic [10:0] obs;
        for (int i = 0; i < 4; i++) begin
            apply(stim[i]);
            sb.push_back('{$sformatf("extest_data[%0d]", i), expv[i]});
            @(negedge clk);
            e = sb.pop_front();
            obs = observed();
            checks++;
            if (obs !== e.value) begin
                errors++;
                $display("[TB] FAIL %s got %b want %b", e.tag, obs, e.value);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_safe_and_unused();
        logic [6:0]  stim [12] = '{7'b1100010, 7'b1100010, 7'b1100000, 7'b1001000, 7'b0000001,
                                   7'b1100010, 7'b1100010, 7'b1100010, 7'b1001000,
                                   7'b0000000, 7'b0110000, 7'b0000001};
        logic [10:0] expv [12] = '{11'b001_0000_101_1, 11'b001_0000_101_0, 11'b001_0000_101_0,
                                   11'b001_0000_101_1, 11'b011_0000_110_1,
                                   11'b011_0000_110_1, 11'b011_0000_110_1, 11'b011_0000_110_0,
                                   11'b011_0000_110_1,
                                   11'b111_0000_000_1, 11'b111_0000_000_1, 11'b111_0000_000_0};
        exp_t e;
        logic [10:0] obs;
        for (int i = 0; i < 12; i++) begin
            apply(stim[i]);
            sb.push_back('{$sformatf("safe_unused[%0d]", i), expv[i]});
            @(negedge clk);
            e = sb.pop_front();
            obs = observed();
            checks++;
            if (obs !== e.value) begin
                errors++;
                $display("[TB] FAIL %s got %b want %b", e.tag, obs, e.value);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_same_cycle();
        logic [6:0]  stim [8] = '{7'b1100000, 7'b1100010, 7'b1100000, 7'b1101010,
                                  7'b1110000, 7'b1100000, 7'b1100000, 7'b1100000};
        logic [10:0] expv [8] = '{11'b111_0000_000_1, 11'b111_0000_000_1, 11'b111_0000_000_1,
                                  11'b111_0000_000_0, 11'b010_0000_100_1,
                                  11'b010_0000_100_0, 11'b010_0000_100_1, 11'b010_0000_100_0};
        exp_t e;
        logic [10:0] obs;
        for (int i = 0; i < 8; i++) begin
            apply(stim[i]);
            sb.push_back('{$sformatf("same_cycle[%0d]", i), expv[i]});
            @(negedge clk);
            e = sb.pop_front();
            obs = observed();
            checks++;
            if (obs !== e.value) begin
                errors++;
                $display("[TB] FAIL %s got %b want %b", e.tag, obs, e.value);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_midshift();
        exp_t e;
        logic [10:0] obs;
        apply(7'b0100011);
        sb.push_back('{"midshift_before", 11'b010_1000_100_1});
        sb.push_back('{"midshift_async", 11'b000_0000_000_0});
        sb.push_back('{"midshift_held", 11'b000_0000_000_0});
        sb.push_back('{"midshift_release", 11'b000_0000_000_1});
        @(negedge clk);
        e = sb.pop_front();
        obs = observed();
        checks++;
        if (obs !== e.value) begin
            errors++;
            $display("[TB] FAIL %s got %b want %b", e.tag, obs, e.value);
        end
        #2;
        arst = 1'b1;
        #1;
        e = sb.pop_front();
        obs = observed();
        checks++;
        if (obs !== e.value) begin
            errors++;
            $display("[TB] FAIL %s got %b want %b", e.tag, obs, e.value);
        end
        @(posedge clk);
        #1;
        e = sb.pop_front();
        obs = observed();
        checks++;
        if (obs !== e.value) begin
            errors++;
            $display("[TB] FAIL %s got %b want %b", e.tag, obs, e.value);
        end
        @(negedge clk);
        arst = 1'b0;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        obs = observed();
        checks++;
        if (obs !== e.value) begin
            errors++;
            $display("[TB] FAIL %s got %b want %b", e.tag, obs, e.value);
        end
        apply(7'b0000000);
    endtask

    // Test sequence: each scenario leaves the registers in the state the next one expects.
    initial begin
        checks = 0;
        errors = 0;
        arst   = 1'b1;
        apply(7'b0000000);
        test_reset();
        test_bypass();
        test_extest_load();
        test_extest_data();
        test_safe_and_unused();
        test_same_cycle();
        test_reset_midshift();
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_drain got %0d entries want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
